// File: rtl/apb_reg_mst_bridge.sv
// APB3 completer driving the register master request/acknowledge handshake.
// A watchdog aborts stalled transfers with a downstream sync reset and PSLVERR.
module apb_reg_mst_bridge #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  mst__fsm__req_vld,
    output logic                  mst__fsm__rd_en,
    output logic                  mst__fsm__wr_en,
    output logic [ADDR_WIDTH-1:0] mst__fsm__addr,
    output logic [DATA_WIDTH-1:0] mst__fsm__wr_data,
    output logic                  mst__fsm__sync_reset,
    output logic                  mst__fsm__ack_rdy,
    input  logic                  fsm__mst__req_rdy,
    input  logic                  fsm__mst__ack_vld,
    input  logic [DATA_WIDTH-1:0] fsm__mst__rd_data
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        ABORT,
        RESP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            pwrite_q;
    logic            expire;
    logic [DATA_WIDTH-1:0] ack_data;

    assign expire   = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign ack_data = pwrite_q ? '0 : fsm__mst__rd_data;

    // Outputs are computed for the state being entered, so they are all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            cnt                  <= '0;
            pwrite_q             <= 1'b0;
            pready               <= 1'b0;
            prdata               <= '0;
            pslverr              <= 1'b0;
            mst__fsm__req_vld    <= 1'b0;
            mst__fsm__rd_en      <= 1'b0;
            mst__fsm__wr_en      <= 1'b0;
            mst__fsm__addr       <= '0;
            mst__fsm__wr_data    <= '0;
            mst__fsm__sync_reset <= 1'b0;
            mst__fsm__ack_rdy    <= 1'b0;
        end else begin
            pready               <= 1'b0;
            prdata               <= '0;
            pslverr              <= 1'b0;
            mst__fsm__req_vld    <= 1'b0;
            mst__fsm__rd_en      <= 1'b0;
            mst__fsm__wr_en      <= 1'b0;
            mst__fsm__sync_reset <= 1'b0;
            mst__fsm__ack_rdy    <= 1'b0;
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        mst__fsm__addr    <= paddr;
                        mst__fsm__wr_data <= pwdata;
                        pwrite_q          <= pwrite;
                        if ((paddr & ALIGN_MASK) != '0) begin
                            state   <= RESP;
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                        end else begin
                            state             <= REQ;
                            cnt               <= '0;
                            mst__fsm__req_vld <= 1'b1;
                            mst__fsm__ack_rdy <= 1'b1;
                            mst__fsm__rd_en   <= !pwrite;
                            mst__fsm__wr_en   <= pwrite;
                        end
                    end
                end
                REQ: begin
                    if (fsm__mst__ack_vld) begin
                        state  <= RESP;
                        pready <= 1'b1;
                        prdata <= ack_data;
                    end else if (expire) begin
                        state                <= ABORT;
                        mst__fsm__sync_reset <= 1'b1;
                    end else if (fsm__mst__req_rdy) begin
                        state             <= WAIT_ACK;
                        cnt               <= cnt + 1'b1;
                        mst__fsm__ack_rdy <= 1'b1;
                    end else begin
                        cnt               <= cnt + 1'b1;
                        mst__fsm__req_vld <= 1'b1;
                        mst__fsm__ack_rdy <= 1'b1;
                        mst__fsm__rd_en   <= !pwrite_q;
                        mst__fsm__wr_en   <= pwrite_q;
                    end
                end
                WAIT_ACK: begin
                    if (fsm__mst__ack_vld) begin
                        state  <= RESP;
                        pready <= 1'b1;
                        prdata <= ack_data;
                    end else if (expire) begin
                        state                <= ABORT;
                        mst__fsm__sync_reset <= 1'b1;
                    end else begin
                        cnt               <= cnt + 1'b1;
                        mst__fsm__ack_rdy <= 1'b1;
                    end
                end
                ABORT: begin
                    state   <= RESP;
                    pready  <= 1'b1;
                    pslverr <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reg_mst_bridge.sv
// Directed bench for apb_reg_mst_bridge with a short watchdog.
module tb_apb_reg_mst_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [63:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        req_vld, rd_en, wr_en;
    logic [63:0] addr;
    logic [31:0] wr_data;
    logic        sync_reset, ack_rdy;
    logic        req_rdy, ack_vld;
    logic [31:0] rd_data;

    int n_chk = 0;
    int n_err = 0;
    int vld_cnt, sr_cnt, rdy_cnt;
    int idx;

    apb_reg_mst_bridge #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .pready(pready),
        .prdata(prdata),
        .pslverr(pslverr),
        .mst__fsm__req_vld(req_vld),
        .mst__fsm__rd_en(rd_en),
        .mst__fsm__wr_en(wr_en),
        .mst__fsm__addr(addr),
        .mst__fsm__wr_data(wr_data),
        .mst__fsm__sync_reset(sync_reset),
        .mst__fsm__ack_rdy(ack_rdy),
        .fsm__mst__req_rdy(req_rdy),
        .fsm__mst__ack_vld(ack_vld),
        .fsm__mst__rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        vld_cnt += int'(req_vld);
        sr_cnt  += int'(sync_reset);
        rdy_cnt += int'(pready);
    endtask

    task automatic clr();
        vld_cnt = 0;
        sr_cnt  = 0;
        rdy_cnt = 0;
    endtask

    task automatic setup(input logic w, input logic [63:0] a, input logic [31:0] d);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        tick();
        penable = 1'b1;
    endtask

    task automatic idle_bus();
        psel    = 1'b0;
        penable = 1'b0;
        req_rdy = 1'b0;
        ack_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        psel = 0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0;
        req_rdy = 0; ack_vld = 0; rd_data = '0;
        clr();
        #1;
        check("rst_outs", {pready, pslverr, req_vld, rd_en, wr_en, sync_reset, ack_rdy}, 0);
        check("rst_addr", addr, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // write, zero wait
        clr();
        setup(1'b1, 64'h10, 32'hDEADBEEF);
        check("wr_req", {req_vld, wr_en, rd_en, ack_rdy, pready}, 5'b11010);
        check("wr_addr", addr, 64'h10);
        check("wr_data", wr_data, 64'hDEADBEEF);
        check("wr_prdata_idle", prdata, 0);
        req_rdy = 1'b1;
        ack_vld = 1'b1;
        rd_data = 32'h5555AAAA;
        tick();
        check("wr_resp", {pready, pslverr, req_vld}, 3'b100);
        check("wr_prdata", prdata, 0);
        idle_bus();
        tick();
        check("wr_done", {pready, vld_cnt[3:0]}, 5'b00001);

        // read with stall
        clr();
        setup(1'b0, 64'h24, 32'h0);
        check("rd_req", {req_vld, rd_en, wr_en}, 3'b110);
        tick();
        tick();
        tick();
        req_rdy = 1'b1;
        tick();
        req_rdy = 1'b0;
        check("rd_wait", {req_vld, rd_en, ack_rdy}, 3'b001);
        check("rd_wait_addr", addr, 64'h24);
        tick();
        ack_vld = 1'b1;
        rd_data = 32'h12345678;
        tick();
        check("rd_resp", {pready, pslverr}, 2'b10);
        check("rd_prdata", prdata, 64'h12345678);
        check("rd_vld_cycles", vld_cnt, 4);
        idle_bus();
        tick();
        check("rd_after", {pready, prdata}, 0);

        // timeout
        clr();
        setup(1'b0, 64'h40, 32'h0);
        req_rdy = 1'b1;
        idx = 0;
        while (!sync_reset && idx < 20) begin
            tick();
            req_rdy = 1'b0;
            idx++;
        end
        check("to_abort_at", idx, 8);
        check("to_abort_outs", {req_vld, ack_rdy, pready}, 0);
        tick();
        check("to_resp", {pready, pslverr, sync_reset}, 3'b110);
        check("to_prdata", prdata, 0);
        check("to_sr_pulses", sr_cnt, 1);
        idle_bus();
        tick();

        // ack in final watchdog cycle
        clr();
        setup(1'b0, 64'h44, 32'h0);
        req_rdy = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            req_rdy = 1'b0;
        end
        ack_vld = 1'b1;
        rd_data = 32'hA5A50001;
        tick();
        check("exp_resp", {pready, pslverr}, 2'b10);
        check("exp_prdata", prdata, 64'hA5A50001);
        idle_bus();
        tick();
        check("exp_no_sr", sr_cnt, 0);

        // unaligned then back-to-back aligned read
        clr();
        setup(1'b1, 64'h13, 32'h11111111);
        check("ua_resp", {pready, pslverr, req_vld}, 3'b110);
        tick();
        check("ua_idle", {pready, pslverr}, 0);
        setup(1'b0, 64'h28, 32'h0);
        check("ua_no_vld", vld_cnt, 1);
        check("b2b_req", {req_vld, rd_en, wr_en}, 3'b110);
        check("b2b_addr", addr, 64'h28);
        req_rdy = 1'b1;
        ack_vld = 1'b1;
        rd_data = 32'hCAFEF00D;
        tick();
        check("b2b_resp", {pready, pslverr}, 2'b10);
        check("b2b_prdata", prdata, 64'hCAFEF00D);
        idle_bus();
        tick();

        // reset mid WAIT_ACK
        clr();
        setup(1'b1, 64'h50, 32'h77);
        req_rdy = 1'b1;
        tick();
        req_rdy = 1'b0;
        check("rw_wait", ack_rdy, 1);
        #2 rst = 1'b1;
        #1;
        check("rw_async", {pready, pslverr, req_vld, rd_en, wr_en, sync_reset, ack_rdy}, 0);
        check("rw_addr", addr, 0);
        check("rw_wdata", wr_data, 0);
        idle_bus();
        @(posedge clk);
        #1 rst = 1'b0;
        ack_vld = 1'b1;
        rd_data = 32'hBAD0BAD0;
        clr();
        for (int i = 0; i < 4; i++) tick();
        check("rw_stale_rdy", rdy_cnt, 0);
        check("rw_stale_sr", sr_cnt, 0);
        check("rw_ack_rdy", ack_rdy, 0);
        ack_vld = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/apb_reg_mst_bridge.md
# apb_reg_mst_bridge

APB3 completer that converts each APB transfer into one request on the register master handshake: req_vld/req_rdy for the request, ack_vld/ack_rdy for the response. It sits directly upstream of the register slave FSM: it drives that FSM's `mst__fsm__*` inputs and consumes its `fsm__mst__*` outputs. A watchdog bounds every transfer. On expiry, the bridge pulses the sync reset downstream and returns PSLVERR.

## Interface
- `ADDR_WIDTH`, default 64: APB and register address width.
- `DATA_WIDTH`, default 32: data width, a power of 2 and at least 8.
- `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles. 0 disables the watchdog.
- `clk` input, 1 bit: the only clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `psel`, `penable`, `pwrite` inputs, 1 bit each: APB3 control.
- `paddr` input, ADDR_WIDTH: APB address.
- `pwdata` input, DATA_WIDTH: APB write data.
- `pready` output, 1 bit: APB ready, registered.
- `prdata` output, DATA_WIDTH: APB read data, registered.
- `pslverr` output, 1 bit: APB error, registered.
- `mst__fsm__req_vld` output, 1 bit: request valid.
- `mst__fsm__rd_en`, `mst__fsm__wr_en` outputs, 1 bit each: access direction. They are one-hot while req_vld=1 and 0 otherwise.
- `mst__fsm__addr` output, ADDR_WIDTH: latched address.
- `mst__fsm__wr_data` output, DATA_WIDTH: latched write data.
- `mst__fsm__sync_reset` output, 1 bit: one-cycle abort pulse.
- `mst__fsm__ack_rdy` output, 1 bit: ready to accept the acknowledge.
- `fsm__mst__req_rdy` input, 1 bit: downstream accepts the request.
- `fsm__mst__ack_vld` input, 1 bit: downstream acknowledge.
- `fsm__mst__rd_data` input, DATA_WIDTH: read data, valid only with ack_vld.

## Operation
- State machine with five states: IDLE, REQ, WAIT_ACK, ABORT, RESP. Every output is a registered or pure state decode; there are no combinational input-to-output paths.
- **IDLE**
  - On `psel & !penable` (setup phase), latch paddr, pwdata and pwrite.
  - If paddr bits [log2(DATA_WIDTH/8)-1:0] are non-zero (unaligned), go to RESP with err=1 and issue no downstream request.
  - Otherwise go to REQ.
- **REQ**
  - Drive req_vld=1, ack_rdy=1, latched addr and wr_data, and rd_en=!pwrite_q, wr_en=pwrite_q.
  - If `fsm__mst__ack_vld` is high, capture rd_data (reads only; writes capture 0) and go to RESP with err=0. This applies whether or not req_rdy is high, because a same-cycle acknowledge completes the transfer.
  - Else if `fsm__mst__req_rdy`, go to WAIT_ACK.
- **WAIT_ACK**
  - Drive req_vld=0, rd_en=wr_en=0, ack_rdy=1. addr and wr_data stay at their latched values.
  - On ack_vld, capture the data and go to RESP with err=0.
- **Watchdog**
  - The counter clears on entry to REQ and increments in each REQ/WAIT_ACK cycle.
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - When the count equals TIMEOUT_CYCLES-1 and ack_vld is low, go to ABORT.
  - If ack_vld and expiry occur in the same cycle, the acknowledge wins.
- **ABORT**
  - Drive mst__fsm__sync_reset=1 for exactly one cycle, with req_vld and ack_rdy at 0.
  - Then go to RESP with err=1 and prdata=0.
- **RESP**
  - pready=1 for exactly one cycle, with prdata and pslverr valid.
  - Then go to IDLE.
  - If psel is low in RESP (protocol violation), the response is dropped and the FSM still returns to IDLE.
- An ack_vld arriving in IDLE, RESP or ABORT is ignored.
- A new setup phase is sampled only in IDLE, so back-to-back APB transfers are legal.

## Timing
- Reset values: every output is 0; the state is IDLE and the counter is 0. Reset mid-transfer abandons the transfer at once and produces no sync_reset pulse.
- Setup sampled at edge N puts REQ in cycle N+1.
- Fastest completion (req_rdy and ack_vld both high in the first REQ cycle) gives pready=1 in cycle N+2. The APB transfer therefore takes a minimum of 3 cycles.
- A downstream that accepts in cycle N+1 and acknowledges k cycles later gives pready in cycle N+2+k.
- Timeout path: ABORT falls TIMEOUT_CYCLES cycles after REQ entry, and pready falls 1 cycle after ABORT. The transfer length is TIMEOUT_CYCLES+3 cycles including setup.
- Unaligned access: pready=1, pslverr=1 in cycle N+1.
- prdata and pslverr are 0 in every cycle where pready=0.

## Test plan
- **Write, zero wait:** setup with paddr=0x10, pwdata=0xDEADBEEF, pwrite=1; req_rdy=1 and ack_vld=1 in the first REQ cycle. Required: one REQ cycle with wr_en=1, addr=0x10, wr_data=0xDEADBEEF; pready=1 two cycles after setup; pslverr=0.
- **Read with stall:** read of 0x24; req_rdy low for 3 REQ cycles, then high; ack_vld with rd_data=0x12345678 two cycles later. Required: req_vld high exactly 4 cycles; prdata=0x12345678 together with pready; pslverr=0.
- **Timeout:** TIMEOUT_CYCLES=8, no ack. Required: sync_reset pulses one cycle after 8 cycles in REQ/WAIT_ACK, then pready=1, pslverr=1, prdata=0.
- **Ack at expiry:** ack_vld lands in the final watchdog cycle. Required: normal completion with pslverr=0 and no sync_reset pulse.
- **Unaligned and back-to-back:** write to 0x13. Required: pready=1, pslverr=1 next cycle and req_vld never asserts. An immediate aligned read that follows must complete normally.
- **Reset mid-WAIT_ACK:** assert rst. Required: all outputs are 0 asynchronously and the state is IDLE. A stale ack_vld after reset release must not produce pready.
